// File: rtl/riscv_pkg.sv
// Shared RV32I memory-stage definitions: funct3 access codes, LSU states and byte-lane width.
package riscv_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RESP, DONE} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    // Unused funct3 size codes fall back to a word access.
    function automatic lsu_size_t f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replication, load shift and sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  lsu_size_t       i_st_size,
    input  logic [1:0]      i_st_off,
    input  logic [31:0]     i_st_data,
    output logic [BE_W-1:0] o_be,
    output logic [31:0]     o_wdata,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_off,
    input  logic [31:0]     i_ld_word,
    output logic [31:0]     o_ld_data
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic        w_signed;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        unique case (i_st_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_be    = 4'b0011 << {i_st_off[1], 1'b0};
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_st_data;
            end
        endcase
    end

    // Low offset bits below the access size are dropped, forcing natural alignment.
    always_comb begin
        w_signed  = ~i_ld_funct3[2];
        w_shamt   = 5'd0;
        o_ld_data = '0;
        unique case (f3_size(i_ld_funct3[1:0]))
            SZ_B:    w_shamt = {i_ld_off, 3'b000};
            SZ_H:    w_shamt = {i_ld_off[1], 4'b0000};
            default: w_shamt = 5'd0;
        endcase
        w_shifted = i_ld_word >> w_shamt;
        unique case (f3_size(i_ld_funct3[1:0]))
            SZ_B:    o_ld_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
            SZ_H:    o_ld_data = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: single-outstanding req/gnt/rvalid bus master with pipeline stall.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of force-aligning.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic [2:0]        funct3_MEM,
    input  logic [ADDR_W-1:0] ADDRESS_MEM,
    input  logic [DATA_W-1:0] WRITE_DATA_MEM,
    output logic [DATA_W-1:0] READ_DATA_MEM,
    output logic              stall_MEM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              misalign_MEM
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;
    logic [31:0] r_load_q;
    logic [1:0]  r_off_q;
    logic [2:0]  r_f3_q;
    logic        r_is_load_q;

    logic        w_op;
    logic        w_misalign;
    lsu_size_t   w_size;
    logic [31:0] w_ld_data;

    // Both MemRead and MemWrite set is treated as a store.
    assign w_op   = MemRead_MEM | MemWrite_MEM;
    assign w_size = f3_size(funct3_MEM[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_op && (r_state == IDLE) &&
                        (((w_size == SZ_H) && ADDRESS_MEM[0]) ||
                         ((w_size == SZ_W) && (ADDRESS_MEM[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign misalign_MEM = w_misalign;
    assign bus_we       = MemWrite_MEM;
    assign bus_addr     = {ADDRESS_MEM[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .i_st_size   (w_size),
        .i_st_off    (ADDRESS_MEM[1:0]),
        .i_st_data   (WRITE_DATA_MEM),
        .o_be        (bus_be),
        .o_wdata     (bus_wdata),
        .i_ld_funct3 (r_f3_q),
        .i_ld_off    (r_off_q),
        .i_ld_word   (r_load_q),
        .o_ld_data   (w_ld_data)
    );

    always_comb begin
        w_state_next  = r_state;
        bus_req       = 1'b0;
        stall_MEM     = 1'b0;
        READ_DATA_MEM = '0;
        unique case (r_state)
            IDLE: begin
                if (w_op && !w_misalign) begin
                    bus_req   = 1'b1;
                    stall_MEM = 1'b1;
                    if (bus_gnt) begin
                        w_state_next = MemWrite_MEM ? DONE : RESP;
                    end
                end
            end
            RESP: begin
                stall_MEM = 1'b1;
                if (bus_rvalid) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                if (r_is_load_q) begin
                    READ_DATA_MEM = w_ld_data;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_load_q    <= '0;
            r_off_q     <= '0;
            r_f3_q      <= '0;
            r_is_load_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && bus_req && bus_gnt) begin
                r_off_q     <= ADDRESS_MEM[1:0];
                r_f3_q      <= funct3_MEM;
                r_is_load_q <= ~MemWrite_MEM;
            end
            if ((r_state == RESP) && bus_rvalid) begin
                r_load_q <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed plan cases plus randomized accesses vs a byte model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_MEM, MemWrite_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] ADDRESS_MEM, WRITE_DATA_MEM, READ_DATA_MEM;
    logic        stall_MEM, bus_req, bus_we, bus_gnt, bus_rvalid, misalign_MEM;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead_MEM    (MemRead_MEM),
        .MemWrite_MEM   (MemWrite_MEM),
        .funct3_MEM     (funct3_MEM),
        .ADDRESS_MEM    (ADDRESS_MEM),
        .WRITE_DATA_MEM (WRITE_DATA_MEM),
        .READ_DATA_MEM  (READ_DATA_MEM),
        .stall_MEM      (stall_MEM),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .misalign_MEM   (misalign_MEM)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: bytes in the naturally aligned window of the access.
    function automatic int sz_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int off_of(input logic [2:0] f3, input logic [31:0] addr);
        int n = sz_of(f3);
        int o = int'(addr[1:0]);
        return o - (o % n);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int n = sz_of(f3);
        logic [31:0] v;
        logic [31:0] m;
        v = word >> (8 * off_of(f3, addr));
        if (n < 4) begin
            m = (32'h1 << (8 * n)) - 32'h1;
            v = v & m;
            if (!f3[2] && v[8*n-1]) v = v | ~m;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be = '0;
        int o = off_of(f3, addr);
        for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + sz_of(f3));
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n = sz_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    // Starts just after a posedge; returns just after the posedge that ends DONE.
    task automatic do_access(input string name, input bit ld, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int gd, input int rvd);
        int stalls = 0;
        int exp_stalls;
        logic [31:0] exp_rd;
        MemRead_MEM = ld; MemWrite_MEM = !ld; funct3_MEM = f3;
        ADDRESS_MEM = addr; WRITE_DATA_MEM = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        for (int c = 0; c <= gd; c++) begin
            bus_gnt = (c == gd);
            @(negedge clk);
            checks++;
            if (bus_req !== 1'b1 || bus_we !== !ld || bus_addr !== {addr[31:2], 2'b00} ||
                bus_be !== ref_be(f3, addr) || misalign_MEM !== 1'b0) begin
                errors++;
                $display("FAIL %s req: req=%b we=%b addr=%h be=%b mis=%b, required 1 %b %h %b 0",
                         name, bus_req, bus_we, bus_addr, bus_be, misalign_MEM, !ld,
                         {addr[31:2], 2'b00}, ref_be(f3, addr));
            end
            if (!ld) begin
                checks++;
                if (bus_wdata !== ref_wdata(f3, wd)) begin
                    errors++;
                    $display("FAIL %s wdata: got %h, required %h", name, bus_wdata,
                             ref_wdata(f3, wd));
                end
            end
            if (stall_MEM === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        bus_gnt = 1'b0;
        if (ld) begin
            for (int c = 0; c <= rvd; c++) begin
                bus_rvalid = (c == rvd);
                bus_rdata  = (c == rvd) ? rd : $urandom;
                @(negedge clk);
                checks++;
                if (bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s resp_req: got %b, required 0", name, bus_req);
                end
                if (stall_MEM === 1'b1) stalls++;
                @(posedge clk); #1;
            end
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
        end
        exp_stalls = gd + 1 + (ld ? rvd + 1 : 0);
        exp_rd = ld ? ref_load(f3, addr, rd) : 32'h0;
        @(negedge clk);
        checks++;
        if (stall_MEM !== 1'b0 || bus_req !== 1'b0 || READ_DATA_MEM !== exp_rd) begin
            errors++;
            $display("FAIL %s done: stall=%b req=%b rdata=%h, required 0 0 %h", name, stall_MEM,
                     bus_req, READ_DATA_MEM, exp_rd);
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, exp_stalls);
        end
        @(posedge clk); #1;
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MemRead_MEM = 0; MemWrite_MEM = 0; funct3_MEM = 0; ADDRESS_MEM = 0; WRITE_DATA_MEM = 0;
        bus_gnt = 0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_MEM !== 0 || bus_req !== 0 || READ_DATA_MEM !== 0 || misalign_MEM !== 0) begin
            errors++;
            $display("FAIL reset: stall=%b req=%b rdata=%h mis=%b, required all 0", stall_MEM,
                     bus_req, READ_DATA_MEM, misalign_MEM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        do_access("sw_0x100", 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
    endtask

    task automatic test_load_byte();
        do_access("lb_0x203", 1, 3'b000, 32'h203, 0, 32'h80AA_BBCC, 0, 0);
    endtask

    task automatic test_load_half();
        do_access("lhu_0x202", 1, 3'b101, 32'h202, 0, 32'h8001_1234, 0, 0);
        do_access("lh_0x202", 1, 3'b001, 32'h202, 0, 32'h8001_1234, 0, 1);
    endtask

    task automatic test_store_byte_wait();
        do_access("sb_0x301_wait", 0, 3'b000, 32'h301, 32'h0000_00A5, 0, 3, 0);
    endtask

    task automatic test_reset_in_resp();
        MemRead_MEM = 1; MemWrite_MEM = 0; funct3_MEM = 3'b010; ADDRESS_MEM = 32'h400;
        bus_gnt = 1;
        @(posedge clk); #1;
        bus_gnt = 0; reset = 1; MemRead_MEM = 0;
        @(posedge clk); #1;
        reset = 0; bus_rvalid = 1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (stall_MEM !== 0 || bus_req !== 0 || READ_DATA_MEM !== 0) begin
            errors++;
            $display("FAIL rst_resp: stall=%b req=%b rdata=%h, required 0 0 0", stall_MEM,
                     bus_req, READ_DATA_MEM);
        end
        @(posedge clk); #1;
        bus_rvalid = 0;
        @(negedge clk);
        checks++;
        if (stall_MEM !== 0 || bus_req !== 0 || READ_DATA_MEM !== 0) begin
            errors++;
            $display("FAIL rst_late_rvalid: stall=%b req=%b rdata=%h, required 0 0 0",
                     stall_MEM, bus_req, READ_DATA_MEM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        MemRead_MEM = 1; MemWrite_MEM = 0; funct3_MEM = 3'b010; ADDRESS_MEM = 32'h102;
        @(negedge clk);
        checks++;
        if (misalign_MEM !== 1 || bus_req !== 0 || stall_MEM !== 0 || READ_DATA_MEM !== 0) begin
            errors++;
            $display("FAIL lw_misalign: mis=%b req=%b stall=%b rdata=%h, required 1 0 0 0",
                     misalign_MEM, bus_req, stall_MEM, READ_DATA_MEM);
        end
        @(posedge clk); #1;
        MemRead_MEM = 0;
        @(negedge clk);
        checks++;
        if (misalign_MEM !== 0) begin
            errors++;
            $display("FAIL misalign_clear: got %b, required 0", misalign_MEM);
        end
        @(posedge clk); #1;
`else
        do_access("lw_0x102", 1, 3'b010, 32'h102, 0, 32'hCAFE_F00D, 0, 0);
        do_access("lh_0x203", 1, 3'b001, 32'h203, 0, 32'h9876_5432, 1, 0);
`endif
    endtask

    task automatic test_random();
        logic [2:0] ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            bit ld = 1'($urandom_range(0, 1));
            logic [2:0] f3 = ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            logic [31:0] a = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            a = a & ~((32'(sz_of(f3))) - 32'h1);
`endif
            do_access("random", ld, f3, a, $urandom, $urandom, $urandom_range(0, 2),
                      $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        do_access("b2b_sh", 0, 3'b001, 32'h0000_0502, 32'h0000_BEEF, 0, 0, 0);
        do_access("b2b_lbu", 1, 3'b100, 32'h0000_0501, 0, 32'h0000_F100, 0, 0);
        do_access("b2b_sw", 0, 3'b010, 32'h0000_0600, 32'h0102_0304, 0, 1, 0);
    endtask

    initial begin
        bus_rdata = 0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half();
        test_store_byte_wait();
        test_reset_in_resp();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Consumes the memory controls, ALU address and store data from EX/MEM.
- Drives a single-outstanding request/grant/rvalid data-memory bus.
- Produces aligned, sign/zero-extended load data for MEM/WB, plus a pipeline stall while an access is in flight.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data width; fixed at 32, byte lanes = DATA_W/8.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- MemRead_MEM  input  1  load instruction in MEM stage.
- MemWrite_MEM  input  1  store instruction in MEM stage.
- funct3_MEM  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ADDRESS_MEM  input  32  effective address from the ALU.
- WRITE_DATA_MEM  input  32  rs2 store data, after forwarding.
- READ_DATA_MEM  output  32  extended load data, to MEM/WB.
- stall_MEM  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
- bus_req  output  1  memory request.
- bus_we  output  1  1 = store.
- bus_addr  output  ADDR_W  word-aligned address; bits [1:0] always 0.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_gnt  input  1  request accepted this cycle.
- bus_rvalid  input  1  load data valid.
- bus_rdata  input  32  load data word.
- misalign_MEM  output  1  misaligned-access flag (see Optional Feature).

Behaviour:
- FSM states: IDLE, RESP, DONE.
- IDLE, no memory op: stall=0, bus_req=0, READ_DATA_MEM=0.
- IDLE, MemRead or MemWrite set: bus_req=1, stall=1, and the bus fields are driven from the inputs.
  - bus_gnt=1 with a store: go to DONE.
  - bus_gnt=1 with a load: go to RESP.
  - bus_gnt=0: stay in IDLE. The inputs are stable because the stall holds EX/MEM.
- RESP: bus_req=0, stall=1.
  - On bus_rvalid, capture bus_rdata into load_q and go to DONE.
  - bus_rvalid in the same cycle as bus_gnt is not legal; the earliest rvalid is the cycle after grant.
- DONE: stall=0, READ_DATA_MEM = extend(load_q) for loads and 0 for stores. MEM/WB captures at this edge. Always go to IDLE next.
- Minimum latency: a store stalls 1 cycle; a load stalls 2 cycles (gnt at cycle 0, rvalid at cycle 1, DONE at cycle 2).
- MemRead and MemWrite both set is an illegal input; treat it as a store.
- Byte enables:
  - Byte access: 4'b0001 << addr[1:0].
  - Half access: 4'b0011 << {addr[1],1'b0}.
  - Word access: 4'b1111.
- Store data replication:
  - SB: data[7:0] on all 4 lanes.
  - SH: data[15:0] on both halves.
  - SW: data as-is.
- Load extraction:
  - Shift load_q right by addr[1:0]*8 (half: addr[1]*16).
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - The address offset is held from the request in a registered off_q.
- Misalignment without the macro: addr low bits below the access size are ignored, so the access is forced to the aligned half/word.
- Reset in any state:
  - Next state is IDLE and load_q = 0.
  - All outputs go to 0 next cycle: bus_req, stall, READ_DATA_MEM and misalign_MEM.
  - An in-flight rvalid after reset is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no bus request and no stall.
  - misalign_MEM=1 for that one cycle and READ_DATA_MEM=0.
  - The trap handler consumes the flag.
- Undefined: misalign_MEM is tied to 0 and the force-align rule applies.

Decomposition:
- riscv_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - the lsu_state_t enum: IDLE/RESP/DONE.
  - a BE_W=4 constant.
- One combinational sub-module, lsu_align, holds:
  - byte-enable generation and store replication.
  - load shift and extension.
- mem_stage_lsu keeps the FSM and the registers.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle:
  - bus_be=1111, bus_addr=0x100, bus_we=1.
  - stall high 1 cycle, DONE next cycle with READ_DATA_MEM=0.
- LB addr 0x203, rdata 0x80AABBCC, gnt at cycle 0, rvalid at cycle 1:
  - bus_addr=0x200.
  - READ_DATA_MEM=0xFFFFFF80 in DONE.
  - stall high for exactly 2 cycles.
- LHU addr 0x202, rdata 0x8001_1234 → 0x00008001. LH on the same data → 0xFFFF8001.
- SB addr 0x301, data 0x000000A5:
  - bus_be=0010, bus_wdata=0xA5A5A5A5.
  - gnt withheld 3 cycles: bus_req and the bus fields stay stable and stall stays high for all 3 cycles.
- Load granted, reset asserted in RESP, rvalid arrives the next cycle:
  - FSM is in IDLE, stall=0, READ_DATA_MEM=0.
  - The late rvalid has no effect.
- LW addr 0x102:
  - With LSU_MISALIGN_TRAP_EN: misalign_MEM=1 for 1 cycle, bus_req=0, stall=0.
  - Without: bus_addr=0x100 and a normal load.
